// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, pipeline control inputs and the F/D register outputs.
// The master modport is the fetch stage; the slave modport is its environment (memory, hazard unit, decode).
interface fetch_stage_if #(
    parameter int unsigned PC_W = 32
);
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_data;
    logic            fd_enable;
    logic            pc_enable;
    logic            flush;
    logic            jump_sel;
    logic [PC_W-1:0] jump_target;
    logic            interrupt;
    logic [5:0]      opcode;
    logic [2:0]      src;
    logic [2:0]      dst;
    logic [15:0]     imm;
    logic            fd_valid;
    logic [PC_W-1:0] fd_pc;
    logic            int_ack;

    modport master (
        output imem_addr,
        input  imem_data,
        input  fd_enable,
        input  pc_enable,
        input  flush,
        input  jump_sel,
        input  jump_target,
        input  interrupt,
        output opcode,
        output src,
        output dst,
        output imm,
        output fd_valid,
        output fd_pc,
        output int_ack
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output fd_enable,
        output pc_enable,
        output flush,
        output jump_sel,
        output jump_target,
        output interrupt,
        input  opcode,
        input  src,
        input  dst,
        input  imm,
        input  fd_valid,
        input  fd_pc,
        input  int_ack
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, two-word instruction assembly (opcode word + optional immediate) and F/D register.
// Optional interrupt injection is built only when FETCH_INT_EN is defined.
module fetch_stage #(
    parameter int unsigned     PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter logic [5:0]      INT_OPCODE = 6'b111111
) (
    input logic           clk,
    input logic           rst,
    fetch_stage_if.master bus
);

    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc;

    // first word of an instruction that carries an immediate
    logic [5:0]      held_op_q, held_op_d;
    logic [2:0]      held_src_q, held_src_d;
    logic [2:0]      held_dst_q, held_dst_d;

    logic [5:0]      opcode_q, opcode_d;
    logic [2:0]      src_q, src_d;
    logic [2:0]      dst_q, dst_d;
    logic [15:0]     imm_q, imm_d;
    logic            fd_valid_q, fd_valid_d;
    logic [PC_W-1:0] fd_pc_q, fd_pc_d;
    logic            int_ack_q, int_ack_d;

    logic            inject;

`ifdef FETCH_INT_EN
    logic            int_pending_q, int_pending_d;

    // only at an instruction boundary, so an immediate is never split
    assign inject = int_pending_q && (state_q == S_OP);

    always_comb begin
        int_pending_d = int_ack_d ? 1'b0 : (int_pending_q | bus.interrupt);
    end
`else
    logic            unused_interrupt;

    assign inject           = 1'b0;
    assign unused_interrupt = bus.interrupt;
`endif

    assign pc_inc = pc_q + PC_W'(1);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        held_op_d  = held_op_q;
        held_src_d = held_src_q;
        held_dst_d = held_dst_q;
        opcode_d   = opcode_q;
        src_d      = src_q;
        dst_d      = dst_q;
        imm_d      = imm_q;
        fd_valid_d = fd_valid_q;
        fd_pc_d    = fd_pc_q;
        int_ack_d  = 1'b0;

        if (bus.flush) begin
            opcode_d   = '0;
            src_d      = '0;
            dst_d      = '0;
            imm_d      = '0;
            fd_valid_d = 1'b0;
            state_d    = S_OP;
            if (bus.jump_sel) begin
                pc_d = bus.jump_target;
            end
        end else if (!bus.fd_enable) begin
            // stall: everything holds except the pulse output
        end else if (bus.jump_sel) begin
            opcode_d   = '0;
            src_d      = '0;
            dst_d      = '0;
            imm_d      = '0;
            fd_valid_d = 1'b0;
            state_d    = S_OP;
            pc_d       = bus.jump_target;
        end else if (!bus.pc_enable) begin
            opcode_d   = '0;
            src_d      = '0;
            dst_d      = '0;
            imm_d      = '0;
            fd_valid_d = 1'b0;
        end else if (inject) begin
            // fd_pc is the not-yet-fetched PC so the handler returns to it
            opcode_d   = INT_OPCODE;
            src_d      = '0;
            dst_d      = '0;
            imm_d      = '0;
            fd_valid_d = 1'b1;
            fd_pc_d    = pc_q;
            int_ack_d  = 1'b1;
        end else if (state_q == S_OP) begin
            pc_d = pc_inc;
            if (bus.imem_data[0]) begin
                held_op_d  = bus.imem_data[15:10];
                held_src_d = bus.imem_data[9:7];
                held_dst_d = bus.imem_data[6:4];
                opcode_d   = '0;
                src_d      = '0;
                dst_d      = '0;
                imm_d      = '0;
                fd_valid_d = 1'b0;
                state_d    = S_IMM;
            end else begin
                opcode_d   = bus.imem_data[15:10];
                src_d      = bus.imem_data[9:7];
                dst_d      = bus.imem_data[6:4];
                imm_d      = '0;
                fd_valid_d = 1'b1;
                fd_pc_d    = pc_inc;
            end
        end else begin
            opcode_d   = held_op_q;
            src_d      = held_src_q;
            dst_d      = held_dst_q;
            imm_d      = bus.imem_data;
            fd_valid_d = 1'b1;
            fd_pc_d    = pc_inc;
            pc_d       = pc_inc;
            state_d    = S_OP;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_OP;
            pc_q          <= RESET_PC;
            held_op_q     <= '0;
            held_src_q    <= '0;
            held_dst_q    <= '0;
            opcode_q      <= '0;
            src_q         <= '0;
            dst_q         <= '0;
            imm_q         <= '0;
            fd_valid_q    <= 1'b0;
            fd_pc_q       <= '0;
            int_ack_q     <= 1'b0;
`ifdef FETCH_INT_EN
            int_pending_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            held_op_q     <= held_op_d;
            held_src_q    <= held_src_d;
            held_dst_q    <= held_dst_d;
            opcode_q      <= opcode_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            imm_q         <= imm_d;
            fd_valid_q    <= fd_valid_d;
            fd_pc_q       <= fd_pc_d;
            int_ack_q     <= int_ack_d;
`ifdef FETCH_INT_EN
            int_pending_q <= int_pending_d;
`endif
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.opcode    = opcode_q;
    assign bus.src       = src_q;
    assign bus.dst       = dst_q;
    assign bus.imm       = imm_q;
    assign bus.fd_valid  = fd_valid_q;
    assign bus.fd_pc     = fd_pc_q;
    assign bus.int_ack   = int_ack_q;

endmodule
